hv_bundle_ctrl: RTL and testbench

// - Sequences the bundling buffer: clears its counters, gates per-item result updates, latches the sign vector, then streams encoded words out.
// - Sits between the encode core (result producer) and the output DMA, one instance per buffer.
// - Stop-and-wait output side. Buffer data arrives 1 cycle after stream_v; dma_valid is held until dma_ready.

---
 rtl/hv_bundle_ctrl_pkg.sv | 29 ++
 rtl/hv_bundle_ctrl_if.sv | 43 ++++
 rtl/hv_bundle_ctrl_perf.sv | 21 ++
 rtl/hv_bundle_ctrl.sv | 80 ++++++++
 tb/tb_hv_bundle_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/hv_bundle_ctrl_pkg.sv
// Shared types and the next-state function for the bundling-buffer controller.
// The RTL and the bench both use next_state(), so the transition rules live in one place.
package hv_ctrl_pkg;

   localparam int HV_WORD_W = 64;
   localparam int HV_CNT_W  = 16;
   localparam int HV_ADDR_W = 8;

   typedef enum logic [2:0] {IDLE, ACCUM, SETTLE, LATCH, ISSUE, OUT} state_t;

   function automatic state_t next_state(input state_t s, input logic start,
                                         input logic item_nz, input logic upd,
                                         input logic cnt_one, input logic dma_ready,
                                         input logic last);
      state_t n;
      n = s;
      case (s)
         IDLE:    n = (start && item_nz) ? ACCUM : IDLE;
         ACCUM:   n = (upd && cnt_one) ? SETTLE : ACCUM;
         SETTLE:  n = LATCH;
         LATCH:   n = ISSUE;
         ISSUE:   n = OUT;
         OUT:     n = !dma_ready ? OUT : (last ? IDLE : ISSUE);
         default: n = IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/hv_bundle_ctrl_if.sv
// Control bundle between the controller, the encode core, the buffer and the DMA.
// Perf counter outputs exist only when HV_CTRL_PERF_EN is defined.
interface hv_bundle_ctrl_if #(
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 8
);
   logic              start;
   logic [CNT_W-1:0]  item_num;
   logic              res_valid;
   logic              res_ready;
   logic              buf_clr;
   logic              update;
   logic              get_fin;
   logic              stream_v;
   logic [ADDR_W-1:0] stream_a;
   logic              dma_valid;
   logic              dma_ready;
   logic              busy;
   logic              done;
   logic              err;
`ifdef HV_CTRL_PERF_EN
   logic [31:0]       perf_busy;
   logic [31:0]       perf_stall;
`endif

   modport master (
      input  start, item_num, res_valid, dma_ready,
      output res_ready, buf_clr, update, get_fin, stream_v, stream_a,
             dma_valid, busy, done, err
`ifdef HV_CTRL_PERF_EN
      , output perf_busy, perf_stall
`endif
   );

   modport slave (
      output start, item_num, res_valid, dma_ready,
      input  res_ready, buf_clr, update, get_fin, stream_v, stream_a,
             dma_valid, busy, done, err
`ifdef HV_CTRL_PERF_EN
      , input perf_busy, perf_stall
`endif
   );
endinterface

// File: rtl/hv_bundle_ctrl_perf.sv
// hv_perf_counter: 32-bit saturating event counter, cleared only by rst.
module hv_perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] cnt
);
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/hv_bundle_ctrl.sv
// hv_bundle_ctrl: sequences clear / accumulate / sign-latch / stream for one bundling buffer.
// Optional HV_CTRL_PERF_EN adds busy-cycle and DMA-stall counters.
module hv_bundle_ctrl
   import hv_ctrl_pkg::*;
#(
   parameter int CNT_W  = HV_CNT_W,
   parameter int ADDR_W = HV_ADDR_W,
   parameter int NWORDS = 1
) (
   input logic             clk,
   input logic             rst,
   hv_bundle_ctrl_if.master bus
);
   if (NWORDS < 1 || NWORDS > (1 << ADDR_W)) begin : g_bad_nwords
      $error("hv_bundle_ctrl: NWORDS out of range for ADDR_W");
   end

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              item_nz, accept, upd, last, hs;

   always_comb begin
      item_nz = |bus.item_num;
      accept  = (state_q == IDLE) && bus.start && item_nz;
      upd     = (state_q == ACCUM) && bus.res_valid;
      last    = idx_q == ADDR_W'(NWORDS - 1);
      hs      = (state_q == OUT) && bus.dma_ready;
      state_d = next_state(state_q, bus.start, item_nz, upd,
                           cnt_q == CNT_W'(1), bus.dma_ready, last);

      cnt_d = cnt_q;
      if (accept)   cnt_d = bus.item_num;
      else if (upd) cnt_d = cnt_q - CNT_W'(1);

      // idx is reloaded in LATCH, so stream_a holds the last address between vectors
      idx_d = idx_q;
      if (state_q == LATCH)  idx_d = '0;
      else if (hs && !last)  idx_d = idx_q + ADDR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // rst forces every output low in the same cycle, even before state_q resets
   assign bus.res_ready = !rst && (state_q == ACCUM);
   assign bus.update    = !rst && upd;
   assign bus.buf_clr   = !rst && accept;
   assign bus.err       = !rst && (state_q == IDLE) && bus.start && !item_nz;
   assign bus.get_fin   = !rst && (state_q == LATCH);
   assign bus.stream_v  = !rst && (state_q == ISSUE);
   assign bus.stream_a  = rst ? '0 : idx_q;
   assign bus.dma_valid = !rst && (state_q == OUT);
   assign bus.busy      = !rst && (state_q != IDLE);
   assign bus.done      = !rst && hs && last;

`ifdef HV_CTRL_PERF_EN
   hv_perf_counter u_perf_busy (
      .clk (clk),
      .rst (rst),
      .en  (!rst && (state_q != IDLE)),
      .cnt (bus.perf_busy)
   );
   hv_perf_counter u_perf_stall (
      .clk (clk),
      .rst (rst),
      .en  (!rst && (state_q == OUT) && !bus.dma_ready),
      .cnt (bus.perf_stall)
   );
`endif
endmodule

// File: tb/tb_hv_bundle_ctrl.sv
// Directed bench for hv_bundle_ctrl with a behavioural bundling buffer and a word scoreboard.
// Inputs change at negedge; outputs are sampled 1 time unit later, before the next posedge.
module tb_hv_bundle_ctrl;
   localparam int NW   = 2;
   localparam int BITS = NW * 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hv_bundle_ctrl_if #(.CNT_W(16), .ADDR_W(8)) bus ();

   hv_bundle_ctrl #(.CNT_W(16), .ADDR_W(8), .NWORDS(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // behavioural bundling buffer: signed per-bit vote counters
   logic [BITS-1:0] res_data;
   int              acc [BITS];
   logic [BITS-1:0] sgn;
   logic [63:0]     stream_d;

   always @(posedge clk) begin
      for (int i = 0; i < BITS; i++) begin
         if (rst || bus.buf_clr) acc[i] <= 0;
         else if (bus.update)    acc[i] <= acc[i] + (res_data[i] ? 1 : -1);
         if (bus.get_fin)        sgn[i] <= (acc[i] > 0);
      end
      if (bus.stream_v) stream_d <= sgn[int'(bus.stream_a)*64 +: 64];
   end

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb [$];
   logic [BITS-1:0] vec [5];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // bit majority of the first n vectors (n odd), pushed word by word
   task automatic push_majority(input int n);
      logic [BITS-1:0] m;
      int ones;
      for (int b = 0; b < BITS; b++) begin
         ones = 0;
         for (int k = 0; k < n; k++) ones += int'(vec[k][b]);
         m[b] = (ones * 2 > n);
      end
      for (int w = 0; w < NW; w++) sb.push_back(m[w*64 +: 64]);
   endtask

   task automatic gen_vectors(input int n);
      for (int k = 0; k < n; k++) vec[k] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // called right after the cycle of the final update
   task automatic out_phase(input int stall, input bit start_in_done);
      logic [63:0] e;
      @(negedge clk); bus.start = 1'b0; #1;
      chk("settle_res_ready", bus.res_ready, 0);
      chk("settle_no_update", bus.update, 0);
      chk("settle_get_fin", bus.get_fin, 0);
      chk("settle_busy", bus.busy, 1);
      @(negedge clk); bus.res_valid = 1'b0; #1;
      chk("latch_get_fin", bus.get_fin, 1);
      for (int w = 0; w < NW; w++) begin
         @(negedge clk); #1;
         chk("issue_stream_v", bus.stream_v, 1);
         chk("issue_stream_a", bus.stream_a, w);
         chk("issue_dma_valid", bus.dma_valid, 0);
         if (w == 0) begin
            for (int s = 0; s < stall; s++) begin
               @(negedge clk); bus.dma_ready = 1'b0; #1;
               chk("stall_dma_valid", bus.dma_valid, 1);
               chk("stall_stream_v", bus.stream_v, 0);
            end
         end
         @(negedge clk);
         bus.dma_ready = 1'b1;
         if (w == NW - 1 && start_in_done) begin
            bus.start = 1'b1; bus.item_num = 16'd3;
         end
         #1;
         chk("out_dma_valid", bus.dma_valid, 1);
         chk("out_done", bus.done, (w == NW - 1));
         chk("out_buf_clr", bus.buf_clr, 0);
         if (sb.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            e = sb.pop_front();
            chk("stream_d", stream_d, e);
         end
      end
      @(negedge clk); #1;
      chk("post_busy", bus.busy, 0);
      chk("post_done", bus.done, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.item_num = '0; bus.res_valid = 1'b0; bus.dma_ready = 1'b1;
      res_data = '0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1; bus.item_num = 16'd5; #1;
      chk("rst_buf_clr", bus.buf_clr, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_res_ready", bus.res_ready, 0);
      chk("rst_dma_valid", bus.dma_valid, 0);
      chk("rst_done", bus.done, 0);
`ifdef HV_CTRL_PERF_EN
      chk("rst_perf_stall", bus.perf_stall, 0);
`endif

      // item_num == 0 is rejected
      @(negedge clk); rst = 1'b0; bus.item_num = 16'd0; #1;
      chk("zero_err", bus.err, 1);
      chk("zero_buf_clr", bus.buf_clr, 0);
      @(negedge clk); bus.start = 1'b0; #1;
      chk("zero_busy", bus.busy, 0);
      chk("zero_err_pulse", bus.err, 0);

      // reset in the middle of ACCUM after 2 of 5 updates
      @(negedge clk); bus.start = 1'b1; bus.item_num = 16'd5; #1;
      chk("a_buf_clr", bus.buf_clr, 1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); bus.start = 1'b0; bus.res_valid = 1'b1; res_data = '1; #1;
         chk("a_update", bus.update, 1);
      end
      @(negedge clk); rst = 1'b1; bus.res_valid = 1'b0;
      @(negedge clk); rst = 1'b0; #1;
      chk("a_rst_busy", bus.busy, 0);
      chk("a_rst_res_ready", bus.res_ready, 0);

      // fresh 5-item vector, full throughput
      gen_vectors(5); push_majority(5);
      @(negedge clk); bus.start = 1'b1; bus.item_num = 16'd5; #1;
      chk("b_buf_clr", bus.buf_clr, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); bus.start = 1'b0; bus.res_valid = 1'b1; res_data = vec[k]; #1;
         chk("b_update", bus.update, 1);
      end
      out_phase(0, 1'b0);

      // 3 items continuous, 10-cycle DMA stall, start presented in the done cycle
      gen_vectors(3); push_majority(3);
      @(negedge clk); bus.start = 1'b1; bus.item_num = 16'd3; #1;
      chk("c_buf_clr", bus.buf_clr, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); bus.start = 1'b0; bus.res_valid = 1'b1; res_data = vec[k]; #1;
         chk("c_update", bus.update, 1);
      end
      out_phase(10, 1'b1);
`ifdef HV_CTRL_PERF_EN
      chk("perf_stall", bus.perf_stall, 10);
`endif
      // start held from the done cycle is taken on this IDLE cycle
      chk("d_buf_clr", bus.buf_clr, 1);
      gen_vectors(3); push_majority(3);

      // bubbled results with a stray start during ACCUM
      begin
         bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         int j = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.item_num = 16'd7;
            bus.res_valid = pat[k];
            res_data = pat[k] ? vec[j] : ~vec[0];
            if (pat[k]) j++;
            #1;
            chk("d_update", bus.update, pat[k]);
            chk("d_res_ready", bus.res_ready, 1);
         end
      end
      out_phase(0, 1'b0);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
